// File: rtl/debounce_button_array.sv
// Multi-channel pushbutton debouncer: per-channel two-flop synchroniser, polarity
// normalisation, press/release debounce FSM and long-press detection on a shared ms tick.
module debounce_button_array #(
  parameter int                  CLK_RATE        = -1,
  parameter int                  CHANNELS        = 4,
  parameter int                  DEBOUNCE_MS     = 20,
  parameter int                  LONG_PRESS_MS   = 1000,
  parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK = '1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] buttons_a,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] pressStrobe,
  output logic [CHANNELS-1:0] releaseStrobe,
  output logic [CHANNELS-1:0] longPressStrobe,
  output logic                anyPressed
);

  // An un-overridden CLK_RATE degrades to a tick every cycle instead of a zero-length divider.
  localparam int TICK_DIV = (CLK_RATE >= 1000) ? CLK_RATE / 1000 : 1;
  localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W     = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_W   = (LONG_PRESS_MS > 0) ? $clog2(LONG_PRESS_MS + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } state_t;

  logic [PRE_W-1:0] preCnt;
  logic             msTick;

  assign msTick = (preCnt == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      preCnt <= '0;
    end else if (msTick) begin
      preCnt <= '0;
    end else begin
      preCnt <= preCnt + 1'b1;
    end
  end

  (* ASYNC_REG = "TRUE" *) logic [CHANNELS-1:0] syncMeta;
  logic [CHANNELS-1:0] syncOut;
  logic [CHANNELS-1:0] active;

  // Reset loads the inactive pin level so a held button is seen as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syncMeta <= ACTIVE_LOW_MASK;
      syncOut  <= ACTIVE_LOW_MASK;
    end else begin
      syncMeta <= buttons_a;
      syncOut  <= syncMeta;
    end
  end

  assign active = syncOut ^ ACTIVE_LOW_MASK;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : gChan
    state_t          state;
    logic [DB_W-1:0] dbCnt;
    logic            dbDone;
    logic            holdReach;
    logic            pressedReg;
    logic            pressStb;
    logic            releaseStb;
    logic            longStb;

    assign dbDone = msTick && (dbCnt == DB_W'(DEBOUNCE_MS - 1));

    if (LONG_PRESS_MS > 0) begin : gHold
      logic [HOLD_W-1:0] holdCnt;
      logic              holding;

      assign holding   = (state == PRESSED) || (state == RELEASE_PEND);
      assign holdReach = holding && msTick && (holdCnt == HOLD_W'(LONG_PRESS_MS - 1));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          holdCnt <= '0;
        end else if (state == PRESS_PEND && active[gi] && dbDone) begin
          holdCnt <= '0;
        end else if (holding && msTick && holdCnt != HOLD_W'(LONG_PRESS_MS)) begin
          holdCnt <= holdCnt + 1'b1;
        end
      end
    end else begin : gNoHold
      assign holdReach = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state      <= IDLE;
        dbCnt      <= '0;
        pressedReg <= 1'b0;
        pressStb   <= 1'b0;
        releaseStb <= 1'b0;
        longStb    <= 1'b0;
      end else begin
        pressStb   <= 1'b0;
        releaseStb <= 1'b0;
        longStb    <= 1'b0;
        case (state)
          IDLE: begin
            if (active[gi]) begin
              state <= PRESS_PEND;
              dbCnt <= '0;
            end
          end
          PRESS_PEND: begin
            if (!active[gi]) begin
              state <= IDLE;
            end else if (dbDone) begin
              state      <= PRESSED;
              pressedReg <= 1'b1;
              pressStb   <= 1'b1;
            end else if (msTick) begin
              dbCnt <= dbCnt + 1'b1;
            end
          end
          PRESSED: begin
            longStb <= holdReach;
            if (!active[gi]) begin
              state <= RELEASE_PEND;
              dbCnt <= '0;
            end
          end
          RELEASE_PEND: begin
            // An accepted release suppresses a coincident long-press.
            if (active[gi]) begin
              state   <= PRESSED;
              longStb <= holdReach;
            end else if (dbDone) begin
              state      <= IDLE;
              pressedReg <= 1'b0;
              releaseStb <= 1'b1;
            end else begin
              longStb <= holdReach;
              if (msTick) begin
                dbCnt <= dbCnt + 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end

    assign pressed[gi]         = pressedReg;
    assign pressStrobe[gi]     = pressStb;
    assign releaseStrobe[gi]   = releaseStb;
    assign longPressStrobe[gi] = longStb;
  end

  assign anyPressed = |pressed;

endmodule

// File: tb/tb_debounce_button_array.sv
// Scoreboard bench for debounce_button_array: tasks queue expected strobe events with
// cycle windows, a negedge monitor pops and compares each strobe as it appears.
module tb_debounce_button_array;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] buttons_a = 2'b01;
  logic [1:0] pressed;
  logic [1:0] pressStrobe;
  logic [1:0] releaseStrobe;
  logic [1:0] longPressStrobe;
  logic       anyPressed;

  debounce_button_array #(
    .CLK_RATE       (10000),
    .CHANNELS       (2),
    .DEBOUNCE_MS    (3),
    .LONG_PRESS_MS  (10),
    .ACTIVE_LOW_MASK(2'b01)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .buttons_a      (buttons_a),
    .pressed        (pressed),
    .pressStrobe    (pressStrobe),
    .releaseStrobe  (releaseStrobe),
    .longPressStrobe(longPressStrobe),
    .anyPressed     (anyPressed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int ch;
    int lo;
    int hi;
  } exp_t;

  exp_t  expQ[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    lastEvt[3][2];
  string kindName[3] = '{"press", "release", "long"};

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every strobe seen must match the head of the expectation queue.
  always @(negedge clk) begin
    logic hit;
    exp_t e;
    for (int ch = 0; ch < 2; ch++) begin
      for (int k = 0; k < 3; k++) begin
        hit = (k == K_PRESS) ? pressStrobe[ch] : (k == K_REL) ? releaseStrobe[ch] : longPressStrobe[ch];
        if (hit) begin
          lastEvt[k][ch] = cyc;
          tests++;
          if (expQ.size() == 0) begin
            fails++;
            $display("FAIL unexpected_strobe: got %s ch%0d at cycle %0d, required no strobe",
                     kindName[k], ch, cyc);
          end else begin
            e = expQ.pop_front();
            if (e.kind != k || e.ch != ch || cyc < e.lo || cyc > e.hi) begin
              fails++;
              $display("FAIL event_match: got %s ch%0d at cycle %0d, required %s ch%0d in cycles %0d..%0d",
                       kindName[k], ch, cyc, kindName[e.kind], e.ch, e.lo, e.hi);
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input int kind, input int ch, input int lo, input int hi);
    exp_t e;
    e = '{kind, ch, lo, hi};
    expQ.push_back(e);
  endtask

  task automatic test_reset;
    tick(3);
    tests++;
    if ({pressed, pressStrobe, releaseStrobe, longPressStrobe, anyPressed} !== 9'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {pressed, pressStrobe, releaseStrobe, longPressStrobe, anyPressed});
    end
    rst_n = 1'b1;
    tick(30);
    tests++;
    if (pressed !== 2'b00 || anyPressed !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got pressed=%b any=%b, required 00/0", pressed, anyPressed);
    end
  endtask

  task automatic test_press;
    int n;
    n = cyc;
    buttons_a[0] = 1'b0;
    pushExp(K_PRESS, 0, n + 20, n + 33);
    tick(100);
    tests++;
    if (pressed !== 2'b01 || anyPressed !== 1'b1) begin
      fails++;
      $display("FAIL press_level: got pressed=%b any=%b, required 01/1", pressed, anyPressed);
    end
    pushExp(K_LONG, 0, lastEvt[K_PRESS][0] + 100, lastEvt[K_PRESS][0] + 100);
    tick(50);
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("FAIL press_missing_events: got %0d pending, required 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_bounce_release;
    int n;
    buttons_a[0] = 1'b1;
    tick(12);
    buttons_a[0] = 1'b0;
    tick(40);
    tests++;
    if (pressed !== 2'b01) begin
      fails++;
      $display("FAIL bounce_held: got pressed=%b, required 01", pressed);
    end
    n = cyc;
    buttons_a[0] = 1'b1;
    pushExp(K_REL, 0, n + 20, n + 33);
    tick(40);
    tests++;
    if (pressed !== 2'b00 || anyPressed !== 1'b0 || expQ.size() != 0) begin
      fails++;
      $display("FAIL release: got pressed=%b any=%b pending=%0d, required 00/0/0",
               pressed, anyPressed, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_glitch;
    buttons_a[0] = 1'b0;
    tick(15);
    buttons_a[0] = 1'b1;
    tick(60);
    tests++;
    if (pressed !== 2'b00) begin
      fails++;
      $display("FAIL glitch_rejected: got pressed=%b, required 00", pressed);
    end
  endtask

  task automatic test_long_press;
    int n;
    n = cyc;
    buttons_a[1] = 1'b1;
    pushExp(K_PRESS, 1, n + 20, n + 33);
    tick(40);
    tests++;
    if (pressed !== 2'b10) begin
      fails++;
      $display("FAIL ch1_press_level: got pressed=%b, required 10", pressed);
    end
    pushExp(K_LONG, 1, lastEvt[K_PRESS][1] + 100, lastEvt[K_PRESS][1] + 100);
    tick(110);
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("FAIL long_missing: got %0d pending, required 0", expQ.size());
      expQ.delete();
    end
    n = cyc;
    buttons_a[1] = 1'b0;
    pushExp(K_REL, 1, n + 20, n + 33);
    tick(40);
    tests++;
    if (pressed !== 2'b00 || expQ.size() != 0) begin
      fails++;
      $display("FAIL ch1_release: got pressed=%b pending=%0d, required 00/0", pressed, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_back_to_back;
    int n;
    n = cyc;
    buttons_a = 2'b10;
    pushExp(K_PRESS, 0, n + 20, n + 33);
    pushExp(K_PRESS, 1, n + 20, n + 33);
    tick(40);
    tests++;
    if (pressed !== 2'b11 || lastEvt[K_PRESS][0] != lastEvt[K_PRESS][1] || expQ.size() != 0) begin
      fails++;
      $display("FAIL dual_press: got pressed=%b cycles %0d/%0d pending=%0d, required 11, equal, 0",
               pressed, lastEvt[K_PRESS][0], lastEvt[K_PRESS][1], expQ.size());
      expQ.delete();
    end
    n = cyc;
    buttons_a = 2'b01;
    pushExp(K_REL, 0, n + 20, n + 33);
    pushExp(K_REL, 1, n + 20, n + 33);
    tick(40);
    tests++;
    if (pressed !== 2'b00 || lastEvt[K_REL][0] != lastEvt[K_REL][1] || expQ.size() != 0) begin
      fails++;
      $display("FAIL dual_release: got pressed=%b cycles %0d/%0d pending=%0d, required 00, equal, 0",
               pressed, lastEvt[K_REL][0], lastEvt[K_REL][1], expQ.size());
      expQ.delete();
    end
  endtask

  task automatic test_reset_mid;
    int r;
    buttons_a[0] = 1'b0;
    tick(15);
    rst_n = 1'b0;
    #1;
    tests++;
    if (pressed !== 2'b00 || pressStrobe !== 2'b00 || anyPressed !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_pend: got pressed=%b strobe=%b any=%b, required 00/00/0",
               pressed, pressStrobe, anyPressed);
    end
    tick(4);
    rst_n = 1'b1;
    r = cyc;
    pushExp(K_PRESS, 0, r + 20, r + 33);
    tick(40);
    tests++;
    if (pressed !== 2'b01 || expQ.size() != 0) begin
      fails++;
      $display("FAIL redebounce: got pressed=%b pending=%0d, required 01/0", pressed, expQ.size());
      expQ.delete();
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (pressed !== 2'b00 || anyPressed !== 1'b0) begin
      fails++;
      $display("FAIL reset_while_pressed: got pressed=%b any=%b, required 00/0", pressed, anyPressed);
    end
    buttons_a[0] = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(40);
  endtask

  initial begin
    test_reset;
    test_press;
    test_bounce_release;
    test_glitch;
    test_long_press;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
